// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
package serial_add_pkg;

    // Fixed state encodings
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

    typedef enum logic [1:0] {
        StIdle = IDLE,
        StRun  = RUN,
        StDone = DONE
    } state_e;

    // Bit-counter width: enough to count 0..width-1
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Requester-side handshake and operand/result bundle for serial_add_ctrl.
interface serial_add_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/full_adder_bit.sv
// Shared one-bit full adder: two half adders plus an OR for the carry.
module full_adder_bit (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic sum_o,
    output logic cout_o
);
    logic s0, c0, c1;

    halfadder u_ha0 (
        .a_i     (a_i),
        .b_i     (b_i),
        .sum_o   (s0),
        .carry_o (c0)
    );

    halfadder u_ha1 (
        .a_i     (s0),
        .b_i     (c_i),
        .sum_o   (sum_o),
        .carry_o (c1)
    );

    // At most one of the two partial carries can be set
    assign cout_o = c0 | c1;
endmodule

// File: rtl/halfadder.sv
// One-bit half adder.
module halfadder (
    input  logic a_i,
    input  logic b_i,
    output logic sum_o,
    output logic carry_o
);
    assign sum_o   = a_i ^ b_i;
    assign carry_o = a_i & b_i;
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands LSB first,
// one bit per clock, through a single shared full-adder cell.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input logic              clk,
    input logic              rst,
    serial_add_ctrl_if.slave bus
);
    localparam int unsigned CntW = cnt_width(WIDTH);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  a_sr_q, a_sr_d;
    logic [WIDTH-1:0]  b_sr_q, b_sr_d;
    logic [WIDTH-1:0]  ps_q, ps_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              c_q, c_d;
    logic              cout_q, cout_d;
    logic              fa_sum, fa_cout;
    logic              load;
    logic              last_bit;

    full_adder_bit u_fa (
        .a_i    (a_sr_q[0]),
        .b_i    (b_sr_q[0]),
        .c_i    (c_q),
        .sum_o  (fa_sum),
        .cout_o (fa_cout)
    );

    assign last_bit = (cnt_q == CntW'(WIDTH - 1));

    // Next-state: FSM, operand shift, carry, partial sum and result capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        ps_d    = ps_q;
        sum_d   = sum_q;
        c_d     = c_q;
        cout_d  = cout_q;
        load    = 1'b0;

        unique case (state_q)
            StIdle: begin
                load = bus.start;
            end
            StRun: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                c_d    = fa_cout;
                ps_d   = {fa_sum, ps_q[WIDTH-1:1]};
                if (last_bit) begin
                    // Counter holds at WIDTH-1; it never wraps within a transaction
                    state_d = StDone;
                    sum_d   = {fa_sum, ps_q[WIDTH-1:1]};
                    cout_d  = fa_cout;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                // Back-to-back accept skips IDLE
                load = bus.start;
                if (!bus.start) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (load) begin
            state_d = StRun;
            a_sr_d  = bus.a;
            b_sr_d  = bus.b;
            ps_d    = '0;
            c_d     = 1'b0;
            cnt_d   = '0;
        end
    end

    // State register with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            ps_q    <= '0;
            sum_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            ps_q    <= ps_d;
            sum_q   <= sum_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
        end
    end

    assign bus.busy = (state_q == StRun);
    assign bus.done = (state_q == StDone);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl with a cycle-level behavioural model.
module tb_serial_add_ctrl;
    localparam int unsigned WIDTH = 8;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: an accepted request yields a+b exactly WIDTH edges later
    int               m_left = 0;
    logic             m_busy = 1'b0;
    logic             m_done = 1'b0;
    logic [WIDTH-1:0] m_sum  = '0;
    logic             m_cout = 1'b0;
    logic [WIDTH:0]   m_pend = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left <= 0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_sum  <= '0;
            m_cout <= 1'b0;
        end else if (m_left != 0) begin
            m_left <= m_left - 1;
            m_done <= 1'b0;
            if (m_left == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                {m_cout, m_sum} <= m_pend;
            end
        end else if (bus.start) begin
            m_left <= WIDTH;
            m_busy <= 1'b1;
            m_done <= 1'b0;
            m_pend <= {1'b0, bus.a} + {1'b0, bus.b};
        end else begin
            m_done <= 1'b0;
        end
    end

    // Compare DUT against the model every cycle, away from the active edge
    always @(negedge clk) begin
        chk("cyc_busy", 32'(bus.busy), 32'(m_busy));
        chk("cyc_done", 32'(bus.done), 32'(m_done));
        chk("cyc_sum",  32'(bus.sum),  32'(m_sum));
        chk("cyc_cout", 32'(bus.cout), 32'(m_cout));
    end

    // Issue one request and wait (bounded) for done; optionally inject a
    // stray start at loop step inj_k, or skip the leading edge when already in DONE.
    task automatic do_txn(input logic [7:0] ta, input logic [7:0] tb_v,
                          input logic [7:0] es, input logic ec,
                          input bit from_done, input int inj_k, input string nm);
        int k;
        if (!from_done) @(negedge clk);
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tb_v;
        k = 0;
        do begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.a     = 8'hC3;
            bus.b     = 8'h3C;
            k++;
            if (k == inj_k) begin
                bus.start = 1'b1;
                bus.a     = 8'h12;
                bus.b     = 8'h34;
            end
        end while (!bus.done && k < 30);
        bus.start = 1'b0;
        chk({nm, "_latency"}, 32'(k - 1), 32'(WIDTH));
        chk({nm, "_sum"}, 32'(bus.sum), 32'(es));
        chk({nm, "_cout"}, 32'(bus.cout), 32'(ec));
    endtask

    initial begin
        int dones;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        // Reset before any clock edge
        #2;
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_done", 32'(bus.done), 32'h0);
        chk("rst_sum",  32'(bus.sum),  32'h00);
        chk("rst_cout", 32'(bus.cout), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        do_txn(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 0, "zero");
        do_txn(8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 0, "ripple");
        do_txn(8'hA5, 8'h5A, 8'hFF, 1'b0, 1'b0, 0, "alt");
        // Accept again straight from DONE: no IDLE cycle in between
        do_txn(8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 0, "b2b");
        // Stray start sampled at E3 must be ignored
        do_txn(8'h0F, 8'h01, 8'h10, 1'b0, 1'b0, 3, "ignore");
        @(negedge clk);
        chk("ignore_single_done", 32'(bus.done), 32'h0);

        // Abort mid-run with reset
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'hFF;
        bus.b     = 8'hFF;
        repeat (4) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'h0);
        chk("abort_done", 32'(bus.done), 32'h0);
        chk("abort_sum",  32'(bus.sum),  32'h00);
        chk("abort_cout", 32'(bus.cout), 32'h0);
        @(negedge clk);
        rst   = 1'b0;
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        chk("abort_no_done", 32'(dones), 32'h0);
        do_txn(8'h03, 8'h04, 8'h07, 1'b0, 1'b0, 0, "post_rst");

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder controller that time-shares a single one-bit full-adder cell (two `halfadder` instances plus an OR) to add two WIDTH-bit operands, one bit per clock, LSB first. It owns operand shift registers, the carry flop, the bit counter and a start/done handshake. It sits between a requester that presents operands and the shared one-bit add resource, trading latency for area.

## Interface
- `WIDTH`, default 8: operand and result width; legal range is WIDTH >= 2.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  request; sampled on the rising edge only in IDLE or DONE.
- `a`  in  WIDTH  operand A; captured on the accepted `start` edge only.
- `b`  in  WIDTH  operand B; captured on the accepted `start` edge only.
- `busy`  out  1  high while state is RUN.
- `done`  out  1  one-cycle pulse; high while state is DONE.
- `sum`  out  WIDTH  result register; holds the last completed sum.
- `cout`  out  1  carry out of the MSB of the last completed addition.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE: waits for `start`.
  - RUN: processes one bit per cycle.
  - DONE: lasts exactly one cycle.
- Transitions:
  - IDLE, `start`=1 -> RUN. Load `a` and `b` into shift registers, clear the carry flop, clear the counter.
  - RUN -> RUN while count < WIDTH-1.
  - RUN, count = WIDTH-1 -> DONE.
  - DONE, `start`=1 -> RUN. This is a back-to-back accept with the same load actions as from IDLE.
  - DONE, `start`=0 -> IDLE.
- Each RUN edge:
  - bit = a_sr[0] ^ b_sr[0] ^ c
  - c <= carry of that add
  - a_sr and b_sr shift right
  - the bit enters the MSB of the partial-sum shift register
- On the RUN -> DONE edge:
  - `sum` <= final partial-sum register, including the bit computed on that edge.
  - `cout` <= final carry.
- `sum` and `cout` change only on the RUN -> DONE edge. They are stable at all other times, including during a following RUN.
- `start` in RUN is ignored. No queuing; no error flag.
- `a` and `b` are don't-care except on the accepted `start` edge.
- Arithmetic: unsigned modulo 2^WIDTH; `cout` is bit WIDTH of a+b.
- Counter width is $clog2(WIDTH); it never wraps within a transaction.
- Reset (asynchronous, any state, including mid-RUN):
  - state -> IDLE
  - counter, carry and all shift registers -> 0
  - `busy`=0, `done`=0, `sum`=0, `cout`=0
  - No `done` pulse for the aborted transaction.

## Timing
- Accepted `start` at edge E0:
  - RUN occupies edges E1..EWIDTH.
  - `done`=1 and the new `sum`/`cout` are visible from EWIDTH until EWIDTH+1.
  - Latency is WIDTH cycles from the accept edge to `done`.
- `busy` rises at E0 and falls at EWIDTH.
- With back-to-back accepts, throughput is one result per WIDTH+1 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `serial_add_pkg` holds:
  - state encoding localparams: IDLE=2'b00, RUN=2'b01, DONE=2'b10
  - the counter-width helper
- Sub-module `full_adder_bit` is the shared resource. It is built from two existing `halfadder` instances plus an OR for the carry, and is instantiated once.
- The FSM, counter and shift registers live in `serial_add_ctrl`.

## Test plan
- Reset: assert `rst` with no clock -> `busy`=0, `done`=0, `sum`=8'h00, `cout`=0 immediately.
- a=8'h00, b=8'h00, `start` pulse -> `busy` for 8 cycles, `done` pulse at E8, `sum`=8'h00, `cout`=0.
- a=8'hFF, b=8'h01 (full carry ripple) -> `sum`=8'h00, `cout`=1 at E8.
- a=8'hA5, b=8'h5A -> `sum`=8'hFF, `cout`=0. Then hold `start` high through DONE with a=8'h80, b=8'h80 -> second transaction accepted with no IDLE cycle, `sum`=8'h00, `cout`=1 eight cycles later.
- Pulse `start` with a=8'h12, b=8'h34 at E3 while busy with a=8'h0F, b=8'h01 -> ignored; result `sum`=8'h10, `cout`=0, a single `done`.
- Assert `rst` at E4 of a run -> outputs zero immediately, no `done`. After release, a=8'h03, b=8'h04 -> `sum`=8'h07.
